// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and the bit-timing points within
// a 16-tick bit period. Also used by the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam logic [3:0] VOTE_T0 = 4'd7;   // first of three mid-bit samples
    localparam logic [3:0] VOTE_T1 = 4'd9;   // last sample; vote is resolved here
    localparam logic [3:0] BIT_END = 4'd15;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_os16_if.sv
// Receive-side frame buffer interface: data, sideband errors and valid/ready handshake.
interface uart_rx_os16_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Two-flop synchroniser for the raw rxd pad plus a 3-sample majority voter
// taken at ticks 7, 8 and 9 of each bit; vote is meaningful at tick 9.
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_tick,
    input  logic [3:0] tick_cnt,
    input  logic       rxd,
    output logic       rxd_s,
    output logic       vote
);

    logic sync_q1;
    logic sync_q2;
    logic smp_a;
    logic smp_b;

    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the sync chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            smp_a   <= 1'b1;
            smp_b   <= 1'b1;
        end else begin
            sync_q1 <= rxd;
            sync_q2 <= sync_q1;
            if (sample_tick && tick_cnt == VOTE_T0)
                smp_a <= sync_q2;
            if (sample_tick && tick_cnt == (VOTE_T0 + 4'd1))
                smp_b <= sync_q2;
        end
    end

    assign rxd_s = sync_q2;
    assign vote  = majority3(smp_a, smp_b, sync_q2);

endmodule

// File: rtl/uart_rx_os16.sv
// 16x oversampling UART receiver: start validation, majority-voted data bits,
// optional parity, stop check, and a one-entry valid/ready output buffer.
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sample_tick,
    input  logic            rxd,
    input  logic            parity_en,
    input  logic            parity_odd,
    uart_rx_os16_if.master  rx
);

    rx_state_t            state;
    rx_state_t            state_next;
    logic [3:0]           tick_cnt;
    logic [3:0]           bit_idx;
    logic                 armed;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_en_q;
    logic                 par_odd_q;
    logic                 par_err_q;
    logic                 rxd_s;
    logic                 vote;

    logic at_vote;
    logic at_end;
    logic start_go;
    logic shift_en;
    logic par_smp;
    logic complete;

    uart_rx_sampler u_sampler (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .tick_cnt    (tick_cnt),
        .rxd         (rxd),
        .rxd_s       (rxd_s),
        .vote        (vote)
    );

    assign at_vote = sample_tick && (tick_cnt == VOTE_T1);
    assign at_end  = sample_tick && (tick_cnt == BIT_END);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= RX_IDLE;
        else        state <= state_next;
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE:   if (sample_tick && armed && !rxd_s) state_next = RX_START;
            RX_START:  if (at_vote && vote)                state_next = RX_IDLE;
                       else if (at_end)                    state_next = RX_DATA;
            RX_DATA:   if (at_end && bit_idx == 4'(DATA_BITS - 1))
                           state_next = par_en_q ? RX_PARITY : RX_STOP;
            RX_PARITY: if (at_end)                         state_next = RX_STOP;
            RX_STOP:   if (at_vote)                        state_next = RX_IDLE;
            default:                                       state_next = RX_IDLE;
        endcase
    end

    always_comb begin
        start_go = (state == RX_IDLE) && (state_next == RX_START);
        shift_en = (state == RX_DATA) && at_vote;
        par_smp  = (state == RX_PARITY) && at_vote;
        complete = (state == RX_STOP) && at_vote;
    end

    // Frame datapath; frozen entirely while sample_tick is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt  <= '0;
            bit_idx   <= '0;
            armed     <= 1'b0;
            shreg     <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            par_err_q <= 1'b0;
        end else if (sample_tick) begin
            tick_cnt <= (state == RX_IDLE) ? 4'd0 : tick_cnt + 4'd1;
            if (state == RX_IDLE && rxd_s)
                armed <= 1'b1;
            if (complete && !vote)
                armed <= 1'b0;   // break: wait for the line to return high
            if (start_go) begin
                par_en_q  <= parity_en;
                par_odd_q <= parity_odd;
                par_err_q <= 1'b0;
                bit_idx   <= '0;
            end
            if (state == RX_DATA && at_end)
                bit_idx <= bit_idx + 4'd1;
            if (shift_en)
                shreg <= {vote, shreg[DATA_BITS-1:1]};
            if (par_smp)
                par_err_q <= ((^shreg) ^ vote) != par_odd_q;
        end
    end

    // One-entry output buffer; a completing frame may replace an entry
    // being consumed in the same clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx.rx_data    <= '0;
            rx.rx_valid   <= 1'b0;
            rx.parity_err <= 1'b0;
            rx.frame_err  <= 1'b0;
            rx.overrun    <= 1'b0;
        end else begin
            rx.overrun <= 1'b0;
            if (complete) begin
                if (!rx.rx_valid || rx.rx_ready) begin
                    rx.rx_data    <= shreg;
                    rx.parity_err <= par_err_q;
                    rx.frame_err  <= !vote;
                    rx.rx_valid   <= 1'b1;
                end else begin
                    rx.overrun <= 1'b1;
                end
            end else if (rx.rx_valid && rx.rx_ready) begin
                rx.rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Scenario bench for uart_rx_os16: line-level frames are built from the bit
// sequence and expected results come from a frame-level reference model.
module tb_uart_rx_os16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sample_tick = 1'b0;
    logic rxd = 1'b1;
    logic parity_en = 1'b0;
    logic parity_odd = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int ovr_cnt = 0;
    int valid_cnt = 0;
    logic [9:0] got_q[$];   // {parity_err, frame_err, data}

    uart_rx_os16_if #(.DATA_BITS(8)) bus ();

    uart_rx_os16 #(.DATA_BITS(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .rxd         (rxd),
        .parity_en   (parity_en),
        .parity_odd  (parity_odd),
        .rx          (bus)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(posedge clk);
            #2 sample_tick = 1'b1;
            @(posedge clk);
            #2 sample_tick = 1'b0;
        end
    end

    // Records transfers and pulses; all judging happens in the test tasks.
    always @(negedge clk) begin
        if (rst_n && bus.rx_valid && bus.rx_ready)
            got_q.push_back({bus.parity_err, bus.frame_err, bus.rx_data});
        if (rst_n && bus.overrun) ovr_cnt++;
        if (rst_n && bus.rx_valid) valid_cnt++;
    end

    // Reference model: parity error if the count of ones over data+parity
    // disagrees with the selected sense; never flagged when parity is off.
    function automatic logic model_perr(input logic [7:0] d, input logic pe,
                                        input logic pb, input logic odd);
        if (!pe) return 1'b0;
        return (($countones(d) + int'(pb)) % 2 == 1) != odd;
    endfunction

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (64) @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb,
                              input logic sb);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pe) drive_bit(pb);
        drive_bit(sb);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.rx_ready = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", bus.rx_valid); end
        vectors++;
        if (bus.rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h want 00", bus.rx_data); end
        vectors++;
        if ({bus.parity_err, bus.frame_err, bus.overrun} !== 3'b000) begin
            miscompares++; $display("FAIL reset_flags got %b want 000", {bus.parity_err, bus.frame_err, bus.overrun});
        end
        @(posedge clk); #2;
        idle(64);
    endtask

    task automatic test_8n1;
        int v0;
        bus.rx_ready = 1'b1;
        parity_en = 1'b0;
        got_q.delete();
        v0 = valid_cnt;
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        idle(32);
        vectors++;
        if (valid_cnt - v0 != 1) begin miscompares++; $display("FAIL 8n1_valid_cycles got %0d want 1", valid_cnt - v0); end
        vectors++;
        if (got_q.size() != 1) begin miscompares++; $display("FAIL 8n1_count got %0d want 1", got_q.size()); end
        else begin
            vectors++;
            if (got_q[0] !== {2'b00, 8'h55}) begin miscompares++; $display("FAIL 8n1_frame got %h want %h", got_q[0], {2'b00, 8'h55}); end
        end
    endtask

    task automatic test_false_start;
        got_q.delete();
        bus.rx_ready = 1'b1;
        rxd = 1'b0;
        repeat (16) @(posedge clk);
        #2;
        idle(200);
        vectors++;
        if (got_q.size() != 0 || bus.rx_valid !== 1'b0) begin
            miscompares++; $display("FAIL false_start got %0d frames want 0", got_q.size());
        end
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        idle(32);
        vectors++;
        if (got_q.size() != 1 || got_q[0] !== {2'b00, 8'h3C}) begin
            miscompares++; $display("FAIL after_false_start got n=%0d %h want 1 %h", got_q.size(),
                                    (got_q.size() > 0) ? got_q[0] : 10'h0, {2'b00, 8'h3C});
        end
    endtask

    task automatic test_parity;
        logic [9:0] exp;
        bus.rx_ready = 1'b1;
        parity_en = 1'b1;
        parity_odd = 1'b0;
        for (int k = 0; k < 2; k++) begin
            got_q.delete();
            send_frame(8'hA3, 1'b1, (k == 0), 1'b1);
            idle(32);
            exp = {model_perr(8'hA3, 1'b1, (k == 0), 1'b0), 1'b0, 8'hA3};
            vectors++;
            if (got_q.size() != 1 || got_q[0] !== exp) begin
                miscompares++; $display("FAIL parity_a3_%0d got n=%0d %h want %h", k, got_q.size(),
                                        (got_q.size() > 0) ? got_q[0] : 10'h0, exp);
            end
        end
        parity_en = 1'b0;
    endtask

    task automatic test_random;
        logic [7:0] d;
        logic pe, pb, odd;
        logic [9:0] exp;
        bus.rx_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            d   = 8'($urandom);
            pe  = 1'($urandom);
            pb  = 1'($urandom);
            odd = 1'($urandom);
            parity_en = pe;
            parity_odd = odd;
            got_q.delete();
            send_frame(d, pe, pb, 1'b1);
            // config changes after the start bit must not affect this frame
            parity_en = ~pe;
            parity_odd = ~odd;
            idle($urandom_range(24, 60));
            exp = {model_perr(d, pe, pb, odd), 1'b0, d};
            vectors++;
            if (got_q.size() != 1 || got_q[0] !== exp) begin
                miscompares++; $display("FAIL random_%0d got n=%0d %h want %h", k, got_q.size(),
                                        (got_q.size() > 0) ? got_q[0] : 10'h0, exp);
            end
        end
        parity_en = 1'b0;
        parity_odd = 1'b0;
    endtask

    task automatic test_break;
        bus.rx_ready = 1'b1;
        got_q.delete();
        send_frame(8'h00, 1'b0, 1'b0, 1'b0);
        rxd = 1'b0;
        repeat (3 * 640) @(posedge clk);
        #2;
        vectors++;
        if (got_q.size() != 1 || got_q[0] !== {2'b01, 8'h00}) begin
            miscompares++; $display("FAIL break_frame got n=%0d %h want 1 %h", got_q.size(),
                                    (got_q.size() > 0) ? got_q[0] : 10'h0, {2'b01, 8'h00});
        end
        got_q.delete();
        idle(128);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        idle(32);
        vectors++;
        if (got_q.size() != 1 || got_q[0] !== {2'b00, 8'h81}) begin
            miscompares++; $display("FAIL after_break got n=%0d %h want 1 %h", got_q.size(),
                                    (got_q.size() > 0) ? got_q[0] : 10'h0, {2'b00, 8'h81});
        end
    endtask

    task automatic test_overrun;
        int o0;
        bus.rx_ready = 1'b0;
        got_q.delete();
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        idle(16);
        vectors++;
        if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h11) begin
            miscompares++; $display("FAIL ovr_first got v=%b %h want 1 11", bus.rx_valid, bus.rx_data);
        end
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        idle(16);
        vectors++;
        if (bus.rx_data !== 8'h11) begin miscompares++; $display("FAIL ovr_kept got %h want 11", bus.rx_data); end
        vectors++;
        if (ovr_cnt - o0 != 1) begin miscompares++; $display("FAIL ovr_pulses got %0d want 1", ovr_cnt - o0); end
        bus.rx_ready = 1'b1;
        @(posedge clk);
        #2 bus.rx_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.rx_valid !== 1'b0) begin miscompares++; $display("FAIL ovr_drain_valid got %b want 0", bus.rx_valid); end
        vectors++;
        if (got_q.size() != 1 || got_q[0] !== {2'b00, 8'h11}) begin
            miscompares++; $display("FAIL ovr_drain got n=%0d %h want 1 %h", got_q.size(),
                                    (got_q.size() > 0) ? got_q[0] : 10'h0, {2'b00, 8'h11});
        end
        @(posedge clk); #2;
    endtask

    task automatic test_same_clk_ready;
        int o0;
        bit seen;
        bus.rx_ready = 1'b0;
        got_q.delete();
        o0 = ovr_cnt;
        seen = 1'b0;
        fork
            begin
                send_frame(8'h44, 1'b0, 1'b0, 1'b1);
                send_frame(8'h22, 1'b0, 1'b0, 1'b1);
                idle(16);
            end
            begin
                for (int i = 0; i < 1500 && !seen; i++) begin
                    @(negedge clk);
                    if (bus.rx_valid) seen = 1'b1;
                end
                // back-to-back frames complete exactly one frame time apart
                if (seen) begin
                    repeat (639) @(posedge clk);
                    #2 bus.rx_ready = 1'b1;
                    @(posedge clk);
                    #2 bus.rx_ready = 1'b0;
                end
            end
        join
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL same_clk_timeout got no rx_valid want rx_valid within 1500 clk"); end
        vectors++;
        if (got_q.size() != 1 || got_q[0] !== {2'b00, 8'h44}) begin
            miscompares++; $display("FAIL same_clk_accept got n=%0d %h want 1 %h", got_q.size(),
                                    (got_q.size() > 0) ? got_q[0] : 10'h0, {2'b00, 8'h44});
        end
        vectors++;
        if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h22) begin
            miscompares++; $display("FAIL same_clk_buffer got v=%b %h want 1 22", bus.rx_valid, bus.rx_data);
        end
        vectors++;
        if (ovr_cnt != o0) begin miscompares++; $display("FAIL same_clk_overrun got %0d want 0", ovr_cnt - o0); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] d;
        d = 8'h5A;
        parity_en = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        rxd = d[3];
        repeat (32) @(posedge clk);
        #2 rst_n = 1'b0;
        rxd = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.rx_valid, bus.parity_err, bus.frame_err, bus.overrun} !== 4'b0000 || bus.rx_data !== 8'h00) begin
            miscompares++; $display("FAIL mid_reset_outputs got v=%b p=%b f=%b o=%b %h want all 0",
                                    bus.rx_valid, bus.parity_err, bus.frame_err, bus.overrun, bus.rx_data);
        end
        @(posedge clk); #2;
        idle(256);
        got_q.delete();
        bus.rx_ready = 1'b1;
        send_frame(8'hF0, 1'b0, 1'b0, 1'b1);
        idle(32);
        vectors++;
        if (got_q.size() != 1 || got_q[0] !== {2'b00, 8'hF0}) begin
            miscompares++; $display("FAIL after_mid_reset got n=%0d %h want 1 %h", got_q.size(),
                                    (got_q.size() > 0) ? got_q[0] : 10'h0, {2'b00, 8'hF0});
        end
    endtask

    initial begin
        bus.rx_ready = 1'b0;
        @(posedge clk);
        #2;
        test_reset();
        test_8n1();
        test_false_start();
        test_parity();
        test_random();
        test_break();
        test_overrun();
        test_same_clk_ready();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
